// File: rtl/puf_meas_seq.sv
// Ring-oscillator PUF measurement sequencer.
// For every response bit a challenge pair (two oscillator indices) is read from
// challenge memory. Both oscillators are counted over a gated window. The counts
// are compared, and the comparison is repeated C_NVOTE times. The majority vote
// is shifted into the ID register, so the first bit ends up in the MSB.
// Ports:
//   I_sclk, I_osc_rst   system clock, async active-low reset
//   I_osc               free-running oscillator outputs (each clocks its own counter)
//   I_start             run request, honoured in IDLE only
//   I_mem_data          challenge read data, one oscillator index per word
//   O_mem_addr/O_mem_rd challenge read address and one-cycle read strobe
//   O_busy/O_done       run in progress / one-cycle completion pulse
//   O_prim_id           response ID
//   O_unstable          number of bits whose votes were not unanimous
//   O_sel_err           sticky invalid-selector flag, cleared by the next accepted start
module puf_meas_seq #(
  parameter int unsigned C_IOSCNUM      = 48,
  parameter int unsigned C_IOSCDWIDTH   = 24,
  parameter int unsigned C_OIDWIDTH     = 24,
  parameter int unsigned C_MEMDATAWIDTH = 8,
  parameter int unsigned C_MEMADDRWIDTH = 24,
  parameter int unsigned C_MEMSTADDR    = 0,
  parameter int unsigned C_MEMLAT       = 1,
  parameter int unsigned C_WINCYC       = 1024,
  parameter int unsigned C_SETTLE       = 4,
  parameter int unsigned C_NVOTE        = 3
) (
  input  logic                              I_sclk,
  input  logic                              I_osc_rst,
  input  logic [C_IOSCNUM-1:0]              I_osc,
  input  logic                              I_start,
  input  logic [C_MEMDATAWIDTH-1:0]         I_mem_data,
  output logic [C_MEMADDRWIDTH-1:0]         O_mem_addr,
  output logic                              O_mem_rd,
  output logic                              O_busy,
  output logic                              O_done,
  output logic [C_OIDWIDTH-1:0]             O_prim_id,
  output logic [$clog2(C_OIDWIDTH+1)-1:0]   O_unstable,
  output logic                              O_sel_err
);

  localparam int unsigned AW     = C_MEMADDRWIDTH;
  localparam int unsigned DW     = C_MEMDATAWIDTH;
  localparam int unsigned CW     = C_IOSCDWIDTH;
  localparam int unsigned IW     = C_OIDWIDTH;
  localparam int unsigned UW     = $clog2(C_OIDWIDTH + 1);
  localparam int unsigned BW     = $clog2(C_OIDWIDTH + 1);
  localparam int unsigned VW     = $clog2(C_NVOTE + 1);
  localparam int unsigned PH_AB  = (C_MEMLAT + 1 > C_WINCYC) ? C_MEMLAT + 1 : C_WINCYC;
  localparam int unsigned PH_MAX = (PH_AB > C_SETTLE) ? PH_AB : C_SETTLE;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_CLEAR,
    S_WINDOW,
    S_SETTLE,
    S_COMPARE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ph, ph_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic [VW-1:0]   vote_cnt, vote_cnt_n;
  logic [VW-1:0]   ones, ones_n;
  logic [DW-1:0]   sel_a, sel_a_n;
  logic [DW-1:0]   sel_b, sel_b_n;
  logic [IW-1:0]   id_n;
  logic [UW-1:0]   unst_n;
  logic            sel_err_n;
  logic [AW-1:0]   addr_n;
  logic            rd_n;
  logic            gate;
  logic            clr;

  // Oscillator counters: each runs in its own oscillator domain. The gate and
  // clear come from I_sclk registers, and clear acts asynchronously, so a
  // single-cycle CLEAR state suffices regardless of oscillator frequency.
  logic [C_IOSCNUM-1:0][CW-1:0] cnt;

  for (genvar gi = 0; gi < C_IOSCNUM; gi++) begin : g_osc
    logic          cnt_rst_n;
    logic [CW-1:0] cnt_q;

    assign cnt_rst_n = I_osc_rst & ~clr;
    assign cnt[gi]   = cnt_q;

    always_ff @(posedge I_osc[gi] or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
        cnt_q <= '0;
      end else if (gate) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Selected counts; read only in SETTLE/COMPARE, when the gate has been low
  // long enough for every counter to be static.
  logic [CW-1:0] cnt_a, cnt_b;
  logic          sel_ok;
  logic          vote;
  logic          maj;

  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    for (int unsigned i = 0; i < C_IOSCNUM; i++) begin
      if (32'(sel_a) == i) cnt_a = cnt[i];
      if (32'(sel_b) == i) cnt_b = cnt[i];
    end
  end

  assign sel_ok = (32'(sel_a) < C_IOSCNUM) && (32'(sel_b) < C_IOSCNUM) && (sel_a != sel_b);
  assign vote   = sel_ok && (cnt_a > cnt_b);
  assign maj    = (ones > VW'(C_NVOTE / 2));

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    ph_n       = ph;
    bit_cnt_n  = bit_cnt;
    vote_cnt_n = vote_cnt;
    ones_n     = ones;
    sel_a_n    = sel_a;
    sel_b_n    = sel_b;
    id_n       = O_prim_id;
    unst_n     = O_unstable;
    sel_err_n  = O_sel_err;
    addr_n     = O_mem_addr;
    rd_n       = 1'b0;

    case (state)
      S_IDLE: begin
        if (I_start) begin
          id_n       = '0;
          unst_n     = '0;
          sel_err_n  = 1'b0;
          bit_cnt_n  = '0;
          vote_cnt_n = '0;
          ones_n     = '0;
          ph_n       = '0;
          state_n    = S_FETCH_A;
        end
      end

      S_FETCH_A: begin
        if (ph == PW'(C_MEMLAT)) begin
          sel_a_n = I_mem_data;
          ph_n    = '0;
          state_n = S_FETCH_B;
        end else begin
          ph_n = ph + PW'(1);
        end
      end

      S_FETCH_B: begin
        if (ph == PW'(C_MEMLAT)) begin
          sel_b_n = I_mem_data;
          ph_n    = '0;
          state_n = S_CLEAR;
        end else begin
          ph_n = ph + PW'(1);
        end
      end

      S_CLEAR: begin
        ph_n    = '0;
        state_n = S_WINDOW;
      end

      S_WINDOW: begin
        if (ph == PW'(C_WINCYC - 1)) begin
          ph_n    = '0;
          state_n = S_SETTLE;
        end else begin
          ph_n = ph + PW'(1);
        end
      end

      S_SETTLE: begin
        if (ph == PW'(C_SETTLE - 1)) begin
          ph_n    = '0;
          state_n = S_COMPARE;
        end else begin
          ph_n = ph + PW'(1);
        end
      end

      S_COMPARE: begin
        ones_n     = ones + VW'(vote);
        vote_cnt_n = vote_cnt + VW'(1);
        if (!sel_ok) sel_err_n = 1'b1;
        state_n = (vote_cnt_n < VW'(C_NVOTE)) ? S_CLEAR : S_SHIFT;
      end

      S_SHIFT: begin
        id_n = (O_prim_id << 1) | IW'(maj);
        // An invalid pair forces all votes to 0, so it never counts as unstable.
        if ((ones != '0) && (ones != VW'(C_NVOTE))) unst_n = O_unstable + UW'(1);
        ones_n     = '0;
        vote_cnt_n = '0;
        ph_n       = '0;
        bit_cnt_n  = bit_cnt + BW'(1);
        state_n    = (bit_cnt_n == BW'(C_OIDWIDTH)) ? S_DONE : S_FETCH_A;
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Read strobe and address are issued on entry to each fetch state.
    if ((state_n == S_FETCH_A) && (state != S_FETCH_A)) begin
      rd_n   = 1'b1;
      addr_n = AW'(C_MEMSTADDR) + (AW'(bit_cnt_n) << 1);
    end
    if ((state_n == S_FETCH_B) && (state != S_FETCH_B)) begin
      rd_n   = 1'b1;
      addr_n = AW'(C_MEMSTADDR) + (AW'(bit_cnt_n) << 1) + AW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge I_sclk or negedge I_osc_rst) begin
    if (!I_osc_rst) begin
      state      <= S_IDLE;
      ph         <= '0;
      bit_cnt    <= '0;
      vote_cnt   <= '0;
      ones       <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      gate       <= 1'b0;
      clr        <= 1'b0;
      O_mem_addr <= AW'(C_MEMSTADDR);
      O_mem_rd   <= 1'b0;
      O_busy     <= 1'b0;
      O_done     <= 1'b0;
      O_prim_id  <= '0;
      O_unstable <= '0;
      O_sel_err  <= 1'b0;
    end else begin
      state      <= state_n;
      ph         <= ph_n;
      bit_cnt    <= bit_cnt_n;
      vote_cnt   <= vote_cnt_n;
      ones       <= ones_n;
      sel_a      <= sel_a_n;
      sel_b      <= sel_b_n;
      gate       <= (state_n == S_WINDOW);
      clr        <= (state_n == S_CLEAR);
      O_mem_addr <= addr_n;
      O_mem_rd   <= rd_n;
      O_busy     <= (state_n != S_IDLE);
      O_done     <= (state_n == S_DONE);
      O_prim_id  <= id_n;
      O_unstable <= unst_n;
      O_sel_err  <= sel_err_n;
    end
  end

endmodule

// File: tb/tb_puf_meas_seq.sv
// Scoreboard bench for puf_meas_seq. Expected results come from a frequency
// model: the oscillator with the shorter period wins a vote. The bench uses a
// main instance (NVOTE=3, MEMLAT=1) and a second instance (NVOTE=1, MEMLAT=3)
// to check latency.
`timescale 1ns/1ps
module tb_puf_meas_seq;

  localparam int NOSC    = 4;
  localparam int OIDW    = 4;
  localparam int L1      = 1;
  localparam int WIN     = 16;
  localparam int SET     = 4;
  localparam int NV      = 3;
  localparam int PER_BIT = 2 * (L1 + 1) + NV * (WIN + SET + 2) + 1;
  localparam int RUN     = 1 + OIDW * PER_BIT;
  localparam int L2      = 3;
  localparam int NV2     = 1;
  localparam int PER_BIT2 = 2 * (L2 + 1) + NV2 * (WIN + SET + 2) + 1;
  localparam int RUN2    = 1 + OIDW * PER_BIT2;

  logic            clk;
  logic            rst_n;
  logic [NOSC-1:0] osc;
  logic            start, start2;
  logic [7:0]      mem_data, mem_data2;
  logic [23:0]     addr, addr2;
  logic            rd, rd2, busy, busy2, done, done2, sel_err, sel_err2;
  logic [OIDW-1:0] id, id2;
  logic [2:0]      unst, unst2;

  puf_meas_seq #(
    .C_IOSCNUM(NOSC), .C_OIDWIDTH(OIDW), .C_MEMLAT(L1),
    .C_WINCYC(WIN), .C_SETTLE(SET), .C_NVOTE(NV)
  ) u_dut (
    .I_sclk(clk), .I_osc_rst(rst_n), .I_osc(osc), .I_start(start),
    .I_mem_data(mem_data), .O_mem_addr(addr), .O_mem_rd(rd), .O_busy(busy),
    .O_done(done), .O_prim_id(id), .O_unstable(unst), .O_sel_err(sel_err)
  );

  puf_meas_seq #(
    .C_IOSCNUM(NOSC), .C_OIDWIDTH(OIDW), .C_MEMLAT(L2),
    .C_WINCYC(WIN), .C_SETTLE(SET), .C_NVOTE(NV2)
  ) u_dut2 (
    .I_sclk(clk), .I_osc_rst(rst_n), .I_osc(osc), .I_start(start2),
    .I_mem_data(mem_data2), .O_mem_addr(addr2), .O_mem_rd(rd2), .O_busy(busy2),
    .O_done(done2), .O_prim_id(id2), .O_unstable(unst2), .O_sel_err(sel_err2)
  );

  // Clocks: 10 ns system clock, oscillators with adjustable half periods.
  real half_p   [NOSC];
  real base_per [NOSC];
  real vper0    [OIDW][NV];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < NOSC; gi++) begin : g_osc
    logic osc_b;
    assign osc[gi] = osc_b;
    initial begin
      osc_b = 1'b0;
      #(0.37 * (gi + 1));
      forever #(half_p[gi]) osc_b = ~osc_b;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Challenge memory with read latency; drives junk outside the valid slot.
  logic [7:0] mem [16];
  logic       vp1 [L1];
  logic [3:0] ap1 [L1];
  logic       vp2 [L2];
  logic [3:0] ap2 [L2];

  always @(posedge clk) begin
    vp1[0] <= rd;
    ap1[0] <= addr[3:0];
    for (int k = 1; k < L1; k++) begin
      vp1[k] <= vp1[k-1];
      ap1[k] <= ap1[k-1];
    end
    vp2[0] <= rd2;
    ap2[0] <= addr2[3:0];
    for (int k = 1; k < L2; k++) begin
      vp2[k] <= vp2[k-1];
      ap2[k] <= ap2[k-1];
    end
  end

  assign mem_data  = vp1[L1-1] ? mem[ap1[L1-1]] : 8'hEE;
  assign mem_data2 = vp2[L2-1] ? mem[ap2[L2-1]] : 8'hEE;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [OIDW-1:0] id;
    int              unst;
    logic            serr;
    int              done_cyc;
  } exp_t;

  exp_t exp_q  [$];
  int   addr_q [$];
  int   pa [OIDW];
  int   pb [OIDW];
  int   exp2_cyc = 0;
  logic [OIDW-1:0] exp2_id = '0;
  int   d2_runs = 0;

  function automatic real per(input int o, input int b, input int v);
    return (o == 0) ? vper0[b][v] : base_per[o];
  endfunction

  // Frequency model: a vote is 1 when osc a has the shorter period.
  function automatic void model(input int nv, output logic [OIDW-1:0] mid,
                                output int mun, output logic mse);
    mid = '0;
    mun = 0;
    mse = 1'b0;
    for (int b = 0; b < OIDW; b++) begin
      bit valid;
      int ones;
      valid = (pa[b] < NOSC) && (pb[b] < NOSC) && (pa[b] != pb[b]);
      ones  = 0;
      if (!valid) mse = 1'b1;
      for (int v = 0; v < nv; v++)
        if (valid && (per(pa[b], b, v) < per(pb[b], b, v))) ones++;
      mid = {mid[OIDW-2:0], (ones > nv / 2)};
      if (ones != 0 && ones != nv) mun++;
    end
  endfunction

  // Scoreboard side: compare read addresses and completion results.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd) begin
        if (addr_q.size() == 0) check_eq("rd_extra", rd, 0);
        else check_eq("rd_addr", addr, addr_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("done_extra", done, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("done_cyc", cyc, e.done_cyc);
          check_eq("done_id", id, e.id);
          check_eq("done_unst", unst, e.unst);
          check_eq("done_serr", sel_err, e.serr);
        end
      end
      if (done2) begin
        d2_runs++;
        check_eq("d2_cyc", cyc, exp2_cyc);
        check_eq("d2_id", id2, exp2_id);
        check_eq("d2_serr", sel_err2, 0);
      end
    end
  end

  task automatic load_mem(input int nbits);
    for (int b = 0; b < OIDW; b++) begin
      mem[2*b]   = 8'(pa[b]);
      mem[2*b+1] = 8'(pb[b]);
    end
    for (int b = 0; b < nbits; b++) begin
      addr_q.push_back(2 * b);
      addr_q.push_back(2 * b + 1);
    end
  endtask

  // Call at a negedge with the DUT in IDLE; returns at the negedge after DONE.
  task automatic start_run(input bit hold);
    exp_t e;
    int n, lowc, k, tgt;
    logic [OIDW-1:0] mid;
    int mun;
    logic mse;
    load_mem(OIDW);
    model(NV, mid, mun, mse);
    n = cyc;
    e.id = mid; e.unst = mun; e.serr = mse; e.done_cyc = n + RUN;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start  = hold;
    start2 = 1'b0;
    check_eq("busy_rise", busy, 1);
    check_eq("id_clr", id, 0);
    check_eq("unst_clr", unst, 0);
    check_eq("serr_clr", sel_err, 0);
    lowc = 0;
    for (int b = 0; b < OIDW; b++) begin
      for (int v = 0; v < NV; v++) begin
        tgt = n + 1 + b * PER_BIT + 2 * (L1 + 1) + v * (WIN + SET + 2);
        while (cyc < tgt) begin
          @(negedge clk);
          if (!busy) lowc++;
        end
        half_p[0] = vper0[b][v] / 2.0;
      end
    end
    k = 0;
    while (!done && k < RUN) begin
      @(negedge clk);
      if (!busy) lowc++;
      k++;
    end
    check_eq("done_seen", done, 1);
    check_eq("busy_gap", lowc, 0);
    half_p[0] = base_per[0] / 2.0;
    @(negedge clk);
    check_eq("busy_fall", busy, 0);
    check_eq("id_hold", id, mid);
    check_eq("unst_hold", unst, mun);
  endtask

  task automatic set_base_vper0();
    for (int b = 0; b < OIDW; b++)
      for (int v = 0; v < NV; v++) vper0[b][v] = base_per[0];
  endtask

  initial begin
    logic [OIDW-1:0] mid;
    int mun, n, cnt;
    logic mse;

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    base_per = '{3.0, 5.0, 7.0, 11.0};
    for (int i = 0; i < NOSC; i++) half_p[i] = base_per[i] / 2.0;
    set_base_vper0();

    repeat (3) @(negedge clk);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_id", id, 0);
    check_eq("rst_unst", unst, 0);
    check_eq("rst_serr", sel_err, 0);
    check_eq("rst_busy2", busy2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Distinct frequencies; second instance runs the same challenges alongside.
    pa = '{0, 2, 3, 1};
    pb = '{1, 1, 0, 0};
    begin
      int saved_q;
      saved_q = 0;
      model(NV2, mid, mun, mse);
      exp2_id  = mid;
      exp2_cyc = cyc + RUN2;
      start2   = 1'b1;
    end
    start_run(1'b0);
    while (d2_runs == 0 && cyc < exp2_cyc + 5) @(negedge clk);
    check_eq("d2_runs", d2_runs, 1);

    // Invalid selectors: out-of-range index and identical pair.
    pa = '{0, 2, 3, 1};
    pb = '{1, 9, 3, 0};
    start_run(1'b0);
    repeat (3) @(negedge clk);
    check_eq("serr_sticky", sel_err, 1);

    // Near-equal oscillators with per-vote period jitter: votes 1,0,1 then 0,1,0.
    pa = '{0, 0, 2, 3};
    pb = '{1, 1, 1, 0};
    vper0[0] = '{4.0, 6.0, 4.0};
    vper0[1] = '{6.0, 4.0, 6.0};
    start_run(1'b0);
    set_base_vper0();

    // Reset in the middle of bit 2's window.
    pa = '{0, 2, 3, 1};
    pb = '{1, 1, 0, 0};
    model(NV, mid, mun, mse);
    load_mem(3);
    n = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + 1 + 2 * PER_BIT + 2 * (L1 + 1) + 1 + 5) @(negedge clk);
    check_eq("pre_rst_id", id, 32'(mid >> 2));
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_id", id, 0);
    check_eq("mid_rst_unst", unst, 0);
    check_eq("mid_rst_addr", addr, 0);
    check_eq("mid_rst_rd", rd, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_addrq", addr_q.size(), 0);
    start_run(1'b0);

    // Start held high: back-to-back runs, then none after release.
    start_run(1'b1);
    start_run(1'b0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check_eq("no_rerun", cnt, 0);

    check_eq("exp_left", exp_q.size(), 0);
    check_eq("addr_left", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
